// File: rtl/pipe_add_seg.sv
// Segment-pipelined adder/subtractor: one SW-bit slice per stage, carry registered between stages.
// Optional signed-overflow output enabled by defining PIPE_ADD_SEG_OVF_EN.
module pipe_add_seg #(
    parameter int WIDTH = 32,
    parameter int SEGS  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co
`ifdef PIPE_ADD_SEG_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int SW = WIDTH / SEGS;
    localparam int L  = SEGS - 1;

    logic             adv;
    logic [SEGS-1:0]  v_q, v_d;
    logic [SEGS-1:0]  c_q, c_d;
    logic [WIDTH-1:0] a_q [SEGS];
    logic [WIDTH-1:0] a_d [SEGS];
    logic [WIDTH-1:0] b_q [SEGS];
    logic [WIDTH-1:0] b_d [SEGS];
    logic [WIDTH-1:0] s_q [SEGS];
    logic [WIDTH-1:0] s_d [SEGS];
`ifdef PIPE_ADD_SEG_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    assign adv       = !v_q[L] | out_ready;
    assign in_ready  = adv;
    assign out_valid = v_q[L];
    assign out_sum   = s_q[L];
    assign out_co    = c_q[L];
`ifdef PIPE_ADD_SEG_OVF_EN
    assign out_ovf   = ovf_q;
`endif

    // Bubble stages carry all-zero data so idle outputs read 0.
    always_comb begin
        logic             sv;
        logic             sc;
        logic [WIDTH-1:0] sa;
        logic [WIDTH-1:0] sb;
        logic [WIDTH-1:0] ss;
        logic [SW:0]      t;
        int               pk;
        sv  = 1'b0;
        sc  = 1'b0;
        sa  = '0;
        sb  = '0;
        ss  = '0;
        t   = '0;
        pk  = 0;
        v_d = '0;
        c_d = '0;
        for (int k = 0; k < SEGS; k++) begin
            a_d[k] = '0;
            b_d[k] = '0;
            s_d[k] = '0;
        end
        for (int k = 0; k < SEGS; k++) begin
            pk = (k == 0) ? 0 : k - 1;
            if (k == 0) begin
                sv = in_valid;
                sa = in_a;
                sb = in_sub ? ~in_b : in_b;
                ss = '0;
                sc = in_sub | in_ci;
            end else begin
                sv = v_q[pk];
                sa = a_q[pk];
                sb = b_q[pk];
                ss = s_q[pk];
                sc = c_q[pk];
            end
            t = {1'b0, sa[k*SW +: SW]} + {1'b0, sb[k*SW +: SW]}
                + {{SW{1'b0}}, sc};
            ss[k*SW +: SW] = t[SW-1:0];
            if (sv) begin
                v_d[k] = 1'b1;
                c_d[k] = t[SW];
                a_d[k] = sa;
                b_d[k] = sb;
                s_d[k] = ss;
            end
        end
`ifdef PIPE_ADD_SEG_OVF_EN
        // Carry into the MSB recovered from its sum bit, xor carry-out.
        ovf_d = a_d[L][WIDTH-1] ^ b_d[L][WIDTH-1] ^ s_d[L][WIDTH-1]
                ^ c_d[L];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            c_q <= '0;
            for (int k = 0; k < SEGS; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
`ifdef PIPE_ADD_SEG_OVF_EN
            ovf_q <= 1'b0;
`endif
        end else if (adv) begin
            v_q <= v_d;
            c_q <= c_d;
            for (int k = 0; k < SEGS; k++) begin
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
                s_q[k] <= s_d[k];
            end
`ifdef PIPE_ADD_SEG_OVF_EN
            ovf_q <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_pipe_add_seg.sv
// Self-checking bench for pipe_add_seg: directed 8-bit vectors and sequences,
// plus randomized 32-bit sweeps at SEGS=1,4,32 against a reference model.
module tb_pipe_add_seg;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // 8-bit, 2-segment instance
    logic       iv8, ir8, ci8, sub8, ov8, or8, co8;
    logic [7:0] a8, b8, s8;
`ifdef PIPE_ADD_SEG_OVF_EN
    logic       ovf8;
`endif

    pipe_add_seg #(.WIDTH(8), .SEGS(2)) u_d8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8),
        .in_a(a8), .in_b(b8), .in_ci(ci8), .in_sub(sub8),
        .out_valid(ov8), .out_ready(or8),
        .out_sum(s8), .out_co(co8)
`ifdef PIPE_ADD_SEG_OVF_EN
        , .out_ovf(ovf8)
`endif
    );

    // 32-bit instances: index 0 -> SEGS=1, 1 -> SEGS=4, 2 -> SEGS=32
    logic        r_iv [3];
    logic        r_ir [3];
    logic        r_ci [3];
    logic        r_sub [3];
    logic        r_ov [3];
    logic        r_or [3];
    logic        r_co [3];
    logic [31:0] r_a [3];
    logic [31:0] r_b [3];
    logic [31:0] r_s [3];
`ifdef PIPE_ADD_SEG_OVF_EN
    logic        r_ovf [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_r
        pipe_add_seg #(
            .WIDTH(32),
            .SEGS((g == 0) ? 1 : ((g == 1) ? 4 : 32))
        ) u_dut (
            .clk(clk), .rst(rst),
            .in_valid(r_iv[g]), .in_ready(r_ir[g]),
            .in_a(r_a[g]), .in_b(r_b[g]), .in_ci(r_ci[g]), .in_sub(r_sub[g]),
            .out_valid(r_ov[g]), .out_ready(r_or[g]),
            .out_sum(r_s[g]), .out_co(r_co[g])
`ifdef PIPE_ADD_SEG_OVF_EN
            , .out_ovf(r_ovf[g])
`endif
        );
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       sub;
        logic [7:0] s;
        logic       co;
        logic       ovf;
        string      name;
    } vec_t;

    typedef struct packed {
        logic [31:0] s;
        logic        co;
        logic        ovf;
    } res_t;

    // Reference: plain unsigned/signed arithmetic on the operands.
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sub);
        res_t        r;
        logic [32:0] w;
        longint      sa, sb, sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sub) begin
            w    = {1'b0, a} - {1'b0, b};
            r.co = (a >= b);
            sr   = sa - sb;
        end else begin
            w    = {1'b0, a} + {1'b0, b} + {32'd0, ci};
            r.co = w[32];
            sr   = sa + sb + longint'(ci);
        end
        r.s   = w[31:0];
        r.ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return r;
    endfunction

    task automatic apply8(input vec_t v);
        int lat;
        @(negedge clk);
        a8 = v.a; b8 = v.b; ci8 = v.ci; sub8 = v.sub;
        iv8 = 1'b1; or8 = 1'b1;
        #1 chk({v.name, "_in_ready"}, ir8, 1);
        @(negedge clk);
        iv8 = 1'b0; a8 = '0; b8 = '0; ci8 = 0; sub8 = 0;
        lat = 1;
        while (!ov8 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        chk({v.name, "_latency"}, lat, 2);
        chk({v.name, "_sum"}, s8, v.s);
        chk({v.name, "_co"}, co8, v.co);
`ifdef PIPE_ADD_SEG_OVF_EN
        chk({v.name, "_ovf"}, ovf8, v.ovf);
`endif
    endtask

    task automatic stall_seq();
        int         c, sent, popped;
        bit         saw_nr, prev_stall;
        logic [7:0] held;
        c = 0; sent = 0; popped = 0; saw_nr = 0; prev_stall = 0; held = '0;
        while (popped < 5 && c < 40) begin
            @(negedge clk);
            c++;
            or8 = !(c >= 3 && c <= 8);
            if (sent < 5) begin
                iv8 = 1'b1;
                a8 = 8'(sent + 1); b8 = 8'(sent + 1);
                ci8 = 0; sub8 = 0;
            end else begin
                iv8 = 1'b0;
            end
            #1;
            if (prev_stall) chk("stall_stable", s8, held);
            if (iv8 && !ir8) begin
                if (!saw_nr) chk("stall_held_count", sent - popped, 2);
                saw_nr = 1;
            end
            if (ov8 && or8) begin
                chk("stall_result", s8, 8'(2 * (popped + 1)));
                popped++;
            end
            prev_stall = ov8 && !or8;
            held = s8;
            if (iv8 && ir8) sent++;
        end
        chk("stall_in_ready_dropped", saw_nr, 1);
        chk("stall_popped", popped, 5);
        @(negedge clk);
        iv8 = 0; or8 = 1;
        #1 chk("stall_no_dup", ov8, 0);
    endtask

    task automatic reset_seq();
        bit any_v;
        vec_t v;
        @(negedge clk);
        iv8 = 1; a8 = 8'h01; b8 = 8'h01; ci8 = 0; sub8 = 0; or8 = 1;
        @(negedge clk);
        a8 = 8'h02; b8 = 8'h02;
        @(negedge clk);
        rst = 1; a8 = 8'h03; b8 = 8'h03;
        @(negedge clk);
        rst = 0; iv8 = 0; a8 = 0; b8 = 0;
        #1;
        chk("rst_out_valid", ov8, 0);
        chk("rst_sum", s8, 0);
        chk("rst_co", co8, 0);
        chk("rst_in_ready", ir8, 1);
        any_v = 0;
        repeat (5) begin
            @(negedge clk);
            #1 any_v |= ov8;
        end
        chk("rst_no_pulse", any_v, 0);
        v = '{8'h0A, 8'h05, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, "after_rst"};
        apply8(v);
    endtask

    task automatic rand_run(input int idx, input int nops);
        res_t q[$];
        res_t e, held;
        int   sent, got, cyc;
        bit   stall;
        sent = 0; got = 0; cyc = 0; stall = 0; held = '0;
        while (got < nops && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (sent < nops) begin
                r_iv[idx]  = ($urandom_range(0, 3) != 0);
                r_a[idx]   = $urandom;
                r_b[idx]   = $urandom;
                r_ci[idx]  = 1'($urandom_range(0, 1));
                r_sub[idx] = 1'($urandom_range(0, 1));
            end else begin
                r_iv[idx] = 1'b0;
            end
            r_or[idx] = ($urandom_range(0, 3) != 0);
            #1;
            if (stall) begin
                chk($sformatf("rand%0d_hold_sum", idx), r_s[idx], held.s);
                chk($sformatf("rand%0d_hold_co", idx), r_co[idx], held.co);
            end
            if (r_ov[idx] && r_or[idx]) begin
                if (q.size() == 0) begin
                    chk($sformatf("rand%0d_unexpected", idx), 1, 0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("rand%0d_sum", idx), r_s[idx], e.s);
                    chk($sformatf("rand%0d_co", idx), r_co[idx], e.co);
`ifdef PIPE_ADD_SEG_OVF_EN
                    chk($sformatf("rand%0d_ovf", idx), r_ovf[idx], e.ovf);
`endif
                end
                got++;
            end
            stall = r_ov[idx] && !r_or[idx];
            held.s = r_s[idx];
            held.co = r_co[idx];
            if (r_iv[idx] && r_ir[idx]) begin
                q.push_back(model(r_a[idx], r_b[idx], r_ci[idx], r_sub[idx]));
                sent++;
            end
        end
        chk($sformatf("rand%0d_done", idx), got, nops);
        r_iv[idx] = 0;
        r_or[idx] = 1;
    endtask

    initial begin
        vec_t tbl[10];
        tbl[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, "ff_p_01"};
        tbl[1] = '{8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, "10_m_20"};
        tbl[2] = '{8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0, "20_m_10"};
        tbl[3] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, "80_p_80"};
        tbl[4] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, "00_m_00"};
        tbl[5] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, "ff_p_ff_c"};
        tbl[6] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, "7f_p_01"};
        tbl[7] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, "80_m_01"};
        tbl[8] = '{8'h05, 8'h03, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0, "05_p_03"};
        tbl[9] = '{8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 1'b0, "3c_p_0f_c"};

        rst = 1;
        iv8 = 0; a8 = 0; b8 = 0; ci8 = 0; sub8 = 0; or8 = 1;
        for (int i = 0; i < 3; i++) begin
            r_iv[i] = 0; r_a[i] = 0; r_b[i] = 0;
            r_ci[i] = 0; r_sub[i] = 0; r_or[i] = 1;
        end
        repeat (3) @(negedge clk);
        rst = 0;
        #1;
        chk("reset_out_valid", ov8, 0);
        chk("reset_sum", s8, 0);
        chk("reset_co", co8, 0);
        chk("reset_in_ready", ir8, 1);
`ifdef PIPE_ADD_SEG_OVF_EN
        chk("reset_ovf", ovf8, 0);
`endif
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset%0d_out_valid", i), r_ov[i], 0);
            chk($sformatf("reset%0d_in_ready", i), r_ir[i], 1);
        end

        for (int i = 0; i < 10; i++) apply8(tbl[i]);
        stall_seq();
        reset_seq();

        for (int i = 0; i < 3; i++) rand_run(i, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_add_seg.md
# pipe_add_seg

Parametrised, segment-pipelined two-operand adder/subtractor with carry-in, carry-out and valid/ready flow control. Successor to the single-cycle combinational adder wrapper. Splits a WIDTH-bit add into SEGS equal slices, one slice per pipeline stage, with the carry registered between stages. Used on datapaths where a full-width carry chain misses timing, and where the consumer can stall.

## Interface
- WIDTH, 32, operand/result width in bits; must be a multiple of SEGS.
- SEGS, 4, number of pipeline segments, 1..WIDTH; slice width SW = WIDTH/SEGS.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operation present.
- in_ready  out  1  block can accept an operation this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_ci  in  1  carry-in; ignored when in_sub=1.
- in_sub  in  1  0: A+B+CI; 1: A−B, computed as A+~B+1.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_sum  out  WIDTH  result, modulo 2^WIDTH.
- out_co  out  1  carry-out of bit WIDTH−1; for subtract, 1 = no borrow (A ≥ B unsigned).
- out_ovf  out  1  signed overflow; present only when PIPE_ADD_SEG_OVF_EN is defined.

## Operation
- Stage k (0..SEGS−1) adds slice k of A and B' (B' = in_sub ? ~B : B) plus the carry from stage k−1. Stage 0 uses in_sub ? 1 : in_ci as its carry.
- Operand slices not yet consumed travel down the pipe with the operation. Completed sum slices are skewed forward so that all WIDTH bits leave together.
- Each stage holds a valid bit. There is one global advance signal: adv = !out_valid | out_ready. When adv=1, every stage loads from its predecessor, and stage 0 loads from the input. When adv=0, every stage holds.
- in_ready = adv. An operation is accepted when in_valid & in_ready. Bubbles propagate as valid=0 stages.
- Any input or handshake-driven stall never alters a held result: out_sum, out_co and out_ovf stay stable while out_valid & !out_ready.
- Arithmetic: out_sum = (A + B' + c0) mod 2^WIDTH, and out_co = bit WIDTH of the (WIDTH+1)-bit sum. These are bit-identical to the unpipelined result for every input.
- SEGS=1 degenerates to a single registered stage.

## Timing
- Latency is exactly SEGS cycles from the accepting edge to out_valid=1, provided out_ready stays high.
- Throughput is one operation per cycle with out_ready held high. Back-to-back operations emerge in order on consecutive cycles.
- Reset values: all stage valid bits 0, out_valid=0, out_sum=0, out_co=0, out_ovf=0, in_ready=1 in the first cycle after reset.
- rst asserted mid-operation discards every in-flight operation. out_valid is 0 from the next edge, and no partial result ever appears.
- rst dominates in_valid in the same cycle; that input is dropped.
- Simultaneous output accept and input accept in the same cycle is allowed. The pipe shifts by one and no operation is lost or duplicated.
- When full and stalled (out_valid=1, out_ready=0), in_ready=0. The pipe holds SEGS operations.

## Configuration
- PIPE_ADD_SEG_OVF_EN defined: the out_ovf port and its logic exist. The MSB stage also registers the carry into bit WIDTH−1, and out_ovf = c_in(MSB) XOR out_co. It is aligned with out_sum and reset to 0.
- PIPE_ADD_SEG_OVF_EN undefined: no out_ovf port and no extra registers. All other behaviour is identical.

## Test plan
- WIDTH=8, SEGS=2. Apply A=0xFF, B=0x01, CI=0, sub=0 with out_ready=1 -> exactly 2 cycles later out_valid=1, out_sum=0x00, out_co=1.
- Subtract A=0x10, B=0x20, sub=1, CI=1 (ignored) -> out_sum=0xF0, out_co=0. Then A=0x20, B=0x10 -> out_sum=0x10, out_co=1.
- Stream 5 back-to-back adds (i+i, i=1..5) with out_ready=0 from cycle 3 to cycle 8:
  - in_ready drops once 2 operations are held.
  - Results 2,4,6,8,10 appear in order with no loss or duplication.
  - out_sum is stable throughout the stall.
- Assert rst for one cycle while 2 operations are in flight -> no out_valid pulse afterward, and all outputs read 0. The next operation, 0x0A+0x05, gives 0x0F after 2 cycles.
- With PIPE_ADD_SEG_OVF_EN: 0x7F+0x01 -> out_sum=0x80, out_ovf=1. 0x80−0x01 -> 0x7F, out_ovf=1. 0x05+0x03 -> out_ovf=0.
- Randomized sweep at WIDTH=32 with SEGS=1, 4 and 32, with random out_ready -> every result matches the reference (WIDTH+1)-bit sum.
